// File: rtl/nfca_pkg.sv
// Shared NFC-A receive-path types and the ADC sample-rate divider constant.
// No logic; imported by the scheduler and the ADC clock generator.
package nfca_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_GUARD,
    RX_WAIT_SOF,
    RX_ACTIVE
  } rx_state_t;

  localparam int ADC_DIV = 32;

endpackage

// File: rtl/nfca_adc_clkgen.sv
// Free-running ADC phase divider: adc_clk, sample capture and one-clk adc_data_en every DIV clk.
// Capture-to-strobe latency 1 clk; no backpressure, the divider never stalls.
module nfca_adc_clkgen
  import nfca_pkg::*;
#(
  parameter int DIV       = ADC_DIV,
  parameter int CAP_PHASE = 20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] adc_raw,
  output logic        adc_clk,
  output logic        adc_data_en,
  output logic [11:0] adc_data
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] HALF = PW'(DIV / 2);
  localparam logic [PW-1:0] CAP  = PW'(CAP_PHASE);

  logic [PW-1:0] r_phase;
  logic          r_adc_clk;
  logic          r_data_en;
  logic [11:0]   r_data;
  logic          w_cap;

  assign w_cap = (r_phase == CAP);

  // DIV is a power of two, so the phase counter wraps on its own.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase   <= '0;
      r_adc_clk <= 1'b0;
      r_data_en <= 1'b0;
      r_data    <= '0;
    end else begin
      r_phase   <= r_phase + 1'b1;
      r_adc_clk <= (r_phase < HALF);
      r_data_en <= w_cap;
      if (w_cap) begin
        r_data <= adc_raw;
      end
    end
  end

  assign adc_clk     = r_adc_clk;
  assign adc_data_en = r_data_en;
  assign adc_data    = r_data;

endmodule

// File: rtl/nfca_rx_sched.sv
// Receive-window sequencer: guard after tx_done, wait for SOF, forward ASK strobes until silence or timeout.
// rx_ask_en -> rx_bit_en 1 clk, tx_done -> busy 1 clk; no backpressure, strobes are consumed as they arrive.
module nfca_rx_sched
  import nfca_pkg::*;
#(
  parameter int DIV             = ADC_DIV,
  parameter int CAP_PHASE       = 20,
  parameter int GUARD_SAMPLES   = 128,
  parameter int TIMEOUT_SAMPLES = 16384,
  parameter int SILENCE_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        adc_clk,
  input  logic [11:0] adc_raw,
  output logic        adc_data_en,
  output logic [11:0] adc_data,
  input  logic        rx_ask_en,
  input  logic        rx_ask,
  input  logic        tx_done,
  input  logic        rx_abort,
  output logic        rx_win,
  output logic        rx_bit_en,
  output logic        rx_bit,
  output logic        rx_end,
  output logic        rx_timeout,
  output logic        busy
);

  localparam int SCNT_W = $clog2(TIMEOUT_SAMPLES) + 1;
  localparam int ZCNT_W = $clog2(SILENCE_SAMPLES) + 1;
  localparam logic [SCNT_W-1:0] GUARD_LAST = SCNT_W'(GUARD_SAMPLES - 1);
  localparam logic [SCNT_W-1:0] TO_LAST    = SCNT_W'(TIMEOUT_SAMPLES - 1);
  localparam logic [ZCNT_W-1:0] SIL_LAST   = ZCNT_W'(SILENCE_SAMPLES - 1);

  rx_state_t          r_state, w_state_nxt;
  logic [SCNT_W-1:0]  r_scnt, w_scnt_nxt;
  logic [ZCNT_W-1:0]  r_zcnt, w_zcnt_nxt;
  logic               w_fwd, w_end, w_timeout;
  logic               r_bit_en, r_bit, r_end, r_timeout;

  nfca_adc_clkgen #(
    .DIV       (DIV),
    .CAP_PHASE (CAP_PHASE)
  ) u_clkgen (
    .clk         (clk),
    .rstn        (rstn),
    .adc_raw     (adc_raw),
    .adc_clk     (adc_clk),
    .adc_data_en (adc_data_en),
    .adc_data    (adc_data)
  );

  // rx_abort beats tx_done beats the strobe; only the strobe advances the counters.
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_zcnt_nxt  = r_zcnt;
    w_fwd       = 1'b0;
    w_end       = 1'b0;
    w_timeout   = 1'b0;
    if (rx_abort) begin
      w_state_nxt = RX_IDLE;
      w_scnt_nxt  = '0;
      w_zcnt_nxt  = '0;
    end else if (tx_done) begin
      w_state_nxt = RX_GUARD;
      w_scnt_nxt  = '0;
      w_zcnt_nxt  = '0;
    end else if (rx_ask_en) begin
      case (r_state)
        RX_IDLE: begin
          w_state_nxt = RX_IDLE;
        end
        RX_GUARD: begin
          if (r_scnt == GUARD_LAST) begin
            w_state_nxt = RX_WAIT_SOF;
            w_scnt_nxt  = '0;
          end else begin
            w_scnt_nxt = r_scnt + 1'b1;
          end
        end
        RX_WAIT_SOF: begin
          if (rx_ask) begin
            w_state_nxt = RX_ACTIVE;
            w_zcnt_nxt  = '0;
            w_fwd       = 1'b1;
          end else if (r_scnt == TO_LAST) begin
            w_state_nxt = RX_IDLE;
            w_scnt_nxt  = '0;
            w_timeout   = 1'b1;
          end else begin
            w_scnt_nxt = r_scnt + 1'b1;
          end
        end
        RX_ACTIVE: begin
          w_fwd = 1'b1;
          if (rx_ask) begin
            w_zcnt_nxt = '0;
          end else if (r_zcnt == SIL_LAST) begin
            w_state_nxt = RX_IDLE;
            w_zcnt_nxt  = '0;
            w_end       = 1'b1;
          end else begin
            w_zcnt_nxt = r_zcnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= RX_IDLE;
      r_scnt    <= '0;
      r_zcnt    <= '0;
      r_bit_en  <= 1'b0;
      r_bit     <= 1'b0;
      r_end     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_scnt    <= w_scnt_nxt;
      r_zcnt    <= w_zcnt_nxt;
      r_bit_en  <= w_fwd;
      r_end     <= w_end;
      r_timeout <= w_timeout;
      if (w_fwd) begin
        r_bit <= rx_ask;
      end
    end
  end

  assign rx_win     = (r_state == RX_ACTIVE);
  assign busy       = (r_state != RX_IDLE);
  assign rx_bit_en  = r_bit_en;
  assign rx_bit     = r_bit;
  assign rx_end     = r_end;
  assign rx_timeout = r_timeout;

endmodule

// File: tb/tb_nfca_rx_sched.sv
// Directed bench for nfca_rx_sched: ADC divider timing, window open/close, silence end, timeout, abort/re-arm priority.
module tb_nfca_rx_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        adc_clk;
  logic [11:0] adc_raw;
  logic        adc_data_en;
  logic [11:0] adc_data;
  logic        rx_ask_en, rx_ask, tx_done, rx_abort;
  logic        rx_win, rx_bit_en, rx_bit, rx_end, rx_timeout, busy;

  always #5 clk = ~clk;

  nfca_rx_sched dut (
    .clk         (clk),
    .rstn        (rstn),
    .adc_clk     (adc_clk),
    .adc_raw     (adc_raw),
    .adc_data_en (adc_data_en),
    .adc_data    (adc_data),
    .rx_ask_en   (rx_ask_en),
    .rx_ask      (rx_ask),
    .tx_done     (tx_done),
    .rx_abort    (rx_abort),
    .rx_win      (rx_win),
    .rx_bit_en   (rx_bit_en),
    .rx_bit      (rx_bit),
    .rx_end      (rx_end),
    .rx_timeout  (rx_timeout),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int n_bit  = 0;
  int n_end  = 0;
  int n_to   = 0;
  int n_both = 0;

  typedef struct packed {
    logic tx, ab, en, ask;
    logic e_win, e_be, e_bit, e_end, e_to, e_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge, then sample outputs 1ns later and tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_bit_en) n_bit++;
    if (rx_end) n_end++;
    if (rx_timeout) n_to++;
    if (rx_end && rx_timeout) n_both++;
  endtask

  task automatic open_window();
    int b;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("busy_after_tx", busy, 1);
    b = n_bit;
    rx_ask_en = 1'b1;
    rx_ask    = 1'b1;
    repeat (128) tick();
    chk("guard_no_bit_en", n_bit - b, 0);
    chk("guard_win", rx_win, 0);
    tick();
    rx_ask_en = 1'b0;
    chk("sof_bit_en", rx_bit_en, 1);
    chk("sof_bit", rx_bit, 1);
    chk("sof_win", rx_win, 1);
  endtask

  task automatic run_to_timeout(output int cnt);
    bit found;
    found = 1'b0;
    cnt = 0;
    rx_ask_en = 1'b1;
    rx_ask    = 1'b0;
    while (!found && cnt < 20000) begin
      tick();
      cnt++;
      if (rx_timeout) found = 1'b1;
    end
    rx_ask_en = 1'b0;
    if (!found) cnt = -1;
  endtask

  initial begin
    int first, last, nstr, hi, b, e, t, c;
    // tx ab en ask | win be bit end to busy
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rstn = 1'b1;
    adc_raw = 12'h5A5;
    rx_ask_en = 1'b0;
    rx_ask = 1'b0;
    tx_done = 1'b0;
    rx_abort = 1'b0;
    #2 rstn = 1'b0;
    #10;
    chk("rst_adc_clk", adc_clk, 0);
    chk("rst_data_en", adc_data_en, 0);
    chk("rst_adc_data", adc_data, 0);
    chk("rst_outputs", {rx_win, rx_bit_en, rx_bit, rx_end, rx_timeout, busy}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // ADC divider: strobes at edges 21, 53, 85, ... ; adc_clk high for 16 of the first 32 edges
    first = 0; last = 0; nstr = 0; hi = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k <= 32 && adc_clk) hi++;
      if (k == 1) chk("adc_clk_edge1", adc_clk, 1);
      if (k == 17) chk("adc_clk_edge17", adc_clk, 0);
      if (adc_data_en) begin
        if (first == 0) first = k;
        else chk("adc_strobe_period", k - last, 32);
        chk("adc_data_5a5", adc_data, 12'h5A5);
        last = k;
        nstr++;
      end
    end
    chk("adc_first_strobe", first, 21);
    chk("adc_strobe_count", nstr, 6);
    chk("adc_clk_high", hi, 16);
    adc_raw = 12'h3C3;
    t = 0;
    while (!adc_data_en && t < 40) begin
      tick();
      t++;
    end
    chk("adc_strobe_seen", adc_data_en, 1);
    chk("adc_data_3c3", adc_data, 12'h3C3);

    // Window closed by 64 silent strobes: 65 forwarded strobes including SOF
    b = n_bit; e = n_end;
    open_window();
    rx_ask_en = 1'b1;
    rx_ask = 1'b0;
    repeat (63) tick();
    chk("sil63_no_end", n_end - e, 0);
    chk("sil63_busy", busy, 1);
    tick();
    rx_ask_en = 1'b0;
    chk("sil64_end", rx_end, 1);
    chk("sil64_bit_en", rx_bit_en, 1);
    chk("sil64_bit", rx_bit, 0);
    chk("sil64_busy", busy, 0);
    chk("sil64_win", rx_win, 0);
    chk("sil_total_bits", n_bit - b, 65);
    tick();
    chk("end_one_clk", rx_end, 0);

    // A one in the silence run restarts the silence count
    b = n_bit;
    open_window();
    rx_ask_en = 1'b1;
    rx_ask = 1'b0;
    repeat (63) tick();
    rx_ask = 1'b1;
    tick();
    rx_ask = 1'b0;
    repeat (63) tick();
    chk("zreset_no_end", rx_end, 0);
    chk("zreset_win", rx_win, 1);
    tick();
    rx_ask_en = 1'b0;
    chk("zreset_end", rx_end, 1);
    chk("zreset_bits", n_bit - b, 129);

    // Priority table starting from ACTIVE right after SOF
    open_window();
    e = n_end; t = n_to;
    for (int i = 0; i < 11; i++) begin
      tx_done   = vecs[i].tx;
      rx_abort  = vecs[i].ab;
      rx_ask_en = vecs[i].en;
      rx_ask    = vecs[i].ask;
      tick();
      tx_done = 1'b0; rx_abort = 1'b0; rx_ask_en = 1'b0; rx_ask = 1'b0;
      chk($sformatf("vec%0d_win", i), rx_win, vecs[i].e_win);
      chk($sformatf("vec%0d_bit_en", i), rx_bit_en, vecs[i].e_be);
      if (vecs[i].e_be) chk($sformatf("vec%0d_bit", i), rx_bit, vecs[i].e_bit);
      chk($sformatf("vec%0d_end", i), rx_end, vecs[i].e_end);
      chk($sformatf("vec%0d_timeout", i), rx_timeout, vecs[i].e_to);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end
    chk("table_no_end", n_end - e, 0);
    chk("table_no_timeout", n_to - t, 0);

    // No SOF: timeout after 128 + 16384 strobes, nothing forwarded
    b = n_bit;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    run_to_timeout(c);
    chk("timeout_strobes", c, 16512);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_bits", n_bit - b, 0);
    tick();
    chk("timeout_one_clk", rx_timeout, 0);

    // Re-arm during WAIT_SOF at scnt=16000 (strobe in the same cycle is ignored)
    t = n_to;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    rx_ask_en = 1'b1;
    rx_ask = 1'b0;
    repeat (128 + 16000) tick();
    chk("rearm_pre_busy", busy, 1);
    chk("rearm_pre_no_to", n_to - t, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("rearm_busy", busy, 1);
    run_to_timeout(c);
    chk("rearm_timeout_strobes", c, 16512);
    chk("rearm_single_timeout", n_to - t, 1);

    chk("end_and_timeout_exclusive", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
